// File: rtl/change_dispenser.sv
// Greedy coin payout controller: releases 20/10/5/1 coins one at a time to the hopper.
// Optional macro CHANGE_TIMEOUT_EN aborts a payout when the hopper never acknowledges.
module change_dispenser #(
    parameter int unsigned STOCK_W      = 4,
    parameter int unsigned STOCK1_INIT  = 8,
    parameter int unsigned STOCK5_INIT  = 8,
    parameter int unsigned STOCK10_INIT = 8,
    parameter int unsigned STOCK20_INIT = 8,
    parameter int unsigned ACK_TIMEOUT  = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [6:0]           amount,
    input  logic                 restock,
    input  logic                 coin_ack,
    output logic                 coin_req,
    output logic [3:0]           coin_sel,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [6:0]           remaining,
    output logic [4*STOCK_W-1:0] stock
);

    typedef enum logic [2:0] {StIdle, StSelect, StReq, StDone, StFail} state_e;

    // Index i of the stock vector matches bit i of the one-hot coin_sel.
    localparam logic [3:0][STOCK_W-1:0] StockInit = {
        STOCK_W'(STOCK20_INIT), STOCK_W'(STOCK10_INIT),
        STOCK_W'(STOCK5_INIT), STOCK_W'(STOCK1_INIT)
    };

    state_e                   state_q, state_d;
    logic [6:0]               remaining_q, remaining_d;
    logic [3:0][STOCK_W-1:0]  stock_q, stock_d;
    logic                     coin_req_q, coin_req_d;
    logic [3:0]               coin_sel_q, coin_sel_d;
    logic                     busy_q, done_q, error_q;
    logic [3:0]               pick;
    logic [6:0]               sel_val;

`ifdef CHANGE_TIMEOUT_EN
    localparam int unsigned TmoW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    logic [TmoW-1:0] tmo_q, tmo_d;
`endif

    // Largest denomination that fits the amount owed and is still in stock.
    always_comb begin
        pick = 4'b0000;
        if (remaining_q >= 7'd20 && stock_q[3] != '0) begin
            pick = 4'b1000;
        end else if (remaining_q >= 7'd10 && stock_q[2] != '0) begin
            pick = 4'b0100;
        end else if (remaining_q >= 7'd5 && stock_q[1] != '0) begin
            pick = 4'b0010;
        end else if (remaining_q >= 7'd1 && stock_q[0] != '0) begin
            pick = 4'b0001;
        end
    end

    always_comb begin
        unique case (coin_sel_q)
            4'b0001: sel_val = 7'd1;
            4'b0010: sel_val = 7'd5;
            4'b0100: sel_val = 7'd10;
            4'b1000: sel_val = 7'd20;
            default: sel_val = 7'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        stock_d     = stock_q;
        coin_req_d  = coin_req_q;
        coin_sel_d  = coin_sel_q;
`ifdef CHANGE_TIMEOUT_EN
        tmo_d       = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (restock) stock_d = StockInit;
                if (start) begin
                    remaining_d = amount;
                    state_d     = StSelect;
                end
            end
            StSelect: begin
                if (remaining_q == 7'd0) begin
                    state_d = StDone;
                end else if (pick == 4'b0000) begin
                    state_d = StFail;
                end else begin
                    coin_sel_d = pick;
                    coin_req_d = 1'b1;
                    state_d    = StReq;
                end
            end
            StReq: begin
                if (coin_ack) begin
                    remaining_d = remaining_q - sel_val;
                    for (int i = 0; i < 4; i++) begin
                        if (coin_sel_q[i]) stock_d[i] = stock_q[i] - STOCK_W'(1);
                    end
                    coin_req_d = 1'b0;
                    coin_sel_d = 4'b0000;
                    state_d    = StSelect;
                end
`ifdef CHANGE_TIMEOUT_EN
                else if (tmo_q == TmoW'(ACK_TIMEOUT - 1)) begin
                    coin_req_d = 1'b0;
                    coin_sel_d = 4'b0000;
                    state_d    = StFail;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
`endif
            end
            StDone:  state_d = StIdle;
            StFail:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            remaining_q <= 7'd0;
            stock_q     <= StockInit;
            coin_req_q  <= 1'b0;
            coin_sel_q  <= 4'b0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            stock_q     <= stock_d;
            coin_req_q  <= coin_req_d;
            coin_sel_q  <= coin_sel_d;
            busy_q      <= (state_d != StIdle);
            done_q      <= (state_d == StDone);
            error_q     <= (state_d == StFail);
        end
    end

`ifdef CHANGE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst) tmo_q <= '0;
        else      tmo_q <= tmo_d;
    end
`endif

    assign coin_req  = coin_req_q;
    assign coin_sel  = coin_sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign remaining = remaining_q;
    assign stock     = stock_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus randomized payouts
// compared against a greedy arithmetic model of the coin stock.
module tb_change_dispenser;

    localparam int SW = 4;
    localparam int Val[4] = '{1, 5, 10, 20};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [6:0]    amount = 7'd0;
    logic          restock = 1'b0;
    logic          coin_ack = 1'b0;
    logic          coin_req;
    logic [3:0]    coin_sel;
    logic          busy, done, error;
    logic [6:0]    remaining;
    logic [4*SW-1:0] stock;

    int n_checks = 0;
    int n_fail   = 0;

    int         mstock[4];
    int         exp_coins[$];
    int         mrem;
    bit         mdone;
    logic [3:0] got_coins[$];
    bit         got_done, got_err, timed_out;
    int         done_cyc, busy_cnt, unstable;
    logic       post_done, post_err, post_busy;

    change_dispenser #(
        .STOCK_W     (SW),
        .STOCK1_INIT (8),
        .STOCK5_INIT (8),
        .STOCK10_INIT(8),
        .STOCK20_INIT(8),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .amount   (amount),
        .restock  (restock),
        .coin_ack (coin_ack),
        .coin_req (coin_req),
        .coin_sel (coin_sel),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .remaining(remaining),
        .stock    (stock)
    );

    always #5 clk = ~clk;

    function automatic void model_fill();
        for (int i = 0; i < 4; i++) mstock[i] = 8;
    endfunction

    // Greedy payout: largest coin that fits and is in stock, until paid or stuck.
    function automatic void model_pay(input int amt);
        int p;
        exp_coins.delete();
        mrem  = amt;
        mdone = 1'b0;
        while (1) begin
            if (mrem == 0) begin
                mdone = 1'b1;
                return;
            end
            p = -1;
            for (int i = 3; i >= 0; i--) begin
                if (Val[i] <= mrem && mstock[i] > 0) begin
                    p = i;
                    break;
                end
            end
            if (p < 0) return;
            exp_coins.push_back(p);
            mrem      -= Val[p];
            mstock[p] -= 1;
        end
    endfunction

    function automatic logic [4*SW-1:0] mvec();
        return {4'(mstock[3]), 4'(mstock[2]), 4'(mstock[1]), 4'(mstock[0])};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        restock = 1'b0;
        coin_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_fill();
    endtask

    task automatic do_restock();
        @(negedge clk);
        restock = 1'b1;
        @(negedge clk);
        restock = 1'b0;
        model_fill();
    endtask

    // Drives one payout, acking each request after dly extra cycles; with noise it also
    // pokes start/restock while the DUT is busy, which must have no effect.
    task automatic payout(input logic [6:0] amt, input int dly, input bit noise);
        got_coins.delete();
        got_done = 1'b0;
        got_err = 1'b0;
        timed_out = 1'b1;
        done_cyc = -1;
        busy_cnt = 0;
        unstable = 0;
        @(negedge clk);
        start = 1'b1;
        amount = amt;
        @(negedge clk);
        start = 1'b0;
        amount = 7'($urandom);
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (busy) busy_cnt++;
            if (done || error) begin
                got_done = done;
                got_err = error;
                done_cyc = cyc;
                timed_out = 1'b0;
                break;
            end
            if (coin_req) begin
                got_coins.push_back(coin_sel);
                for (int k = 0; k < dly; k++) begin
                    if (noise) begin
                        start = 1'b1;
                        amount = 7'($urandom);
                        restock = 1'b1;
                    end
                    @(negedge clk);
                    start = 1'b0;
                    restock = 1'b0;
                    if (busy) busy_cnt++;
                    if (!coin_req || coin_sel !== got_coins[$]) unstable++;
                end
                coin_ack = 1'b1;
                @(negedge clk);
                coin_ack = 1'b0;
                continue;
            end
            @(negedge clk);
        end
        @(negedge clk);
        post_done = done;
        post_err = error;
        post_busy = busy;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 7;
        if (coin_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", coin_req); end
        if (coin_sel !== 4'b0) begin n_fail++; $display("FAIL reset_sel got %b want 0", coin_sel); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", error); end
        if (remaining !== 7'd0) begin n_fail++; $display("FAIL reset_rem got %0d want 0", remaining); end
        if (stock !== 16'h8888) begin n_fail++; $display("FAIL reset_stock got %h want 8888", stock); end
    endtask

    task automatic test_pay37();
        model_pay(37);
        payout(7'd37, 1, 1'b0);
        n_checks += 5;
        if (timed_out) begin n_fail++; $display("FAIL pay37_timeout got no done want done"); end
        if (got_coins.size() != 5) begin
            n_fail++; $display("FAIL pay37_count got %0d want 5", got_coins.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (got_coins[i] !== 4'(1 << exp_coins[i])) begin
                    n_fail++;
                    $display("FAIL pay37_coin%0d got %b want %b", i, got_coins[i],
                             4'(1 << exp_coins[i]));
                end
            end
        end
        if (!got_done) begin n_fail++; $display("FAIL pay37_done got 0 want 1"); end
        if (remaining !== 7'd0) begin n_fail++; $display("FAIL pay37_rem got %0d want 0", remaining); end
        if (stock !== 16'h7776) begin n_fail++; $display("FAIL pay37_stock got %h want 7776", stock); end
    endtask

    task automatic test_zero();
        model_pay(0);
        payout(7'd0, 0, 1'b0);
        n_checks += 5;
        if (got_coins.size() != 0) begin
            n_fail++; $display("FAIL zero_coins got %0d want 0", got_coins.size());
        end
        if (!got_done) begin n_fail++; $display("FAIL zero_done got 0 want 1"); end
        if (done_cyc != 1) begin n_fail++; $display("FAIL zero_latency got %0d want 1", done_cyc); end
        if (busy_cnt != 2) begin n_fail++; $display("FAIL zero_busy got %0d want 2", busy_cnt); end
        if (post_done !== 1'b0 || post_busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_after got done=%b busy=%b want 0 0", post_done, post_busy);
        end
    endtask

    task automatic test_drain20();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            model_pay(20);
            payout(7'd20, 0, 1'b0);
        end
        model_pay(25);
        payout(7'd25, 1, 1'b0);
        n_checks += 4;
        if (got_coins.size() != 3) begin
            n_fail++; $display("FAIL drain20_count got %0d want 3", got_coins.size());
        end else if (got_coins[0] !== 4'b0100 || got_coins[1] !== 4'b0100 ||
                     got_coins[2] !== 4'b0010) begin
            n_fail++; $display("FAIL drain20_seq got %b %b %b want 0100 0100 0010",
                               got_coins[0], got_coins[1], got_coins[2]);
        end
        if (!got_done) begin n_fail++; $display("FAIL drain20_done got 0 want 1"); end
        if (stock[15:12] !== 4'd0) begin
            n_fail++; $display("FAIL drain20_s20 got %0d want 0", stock[15:12]);
        end
        if (stock !== mvec()) begin
            n_fail++; $display("FAIL drain20_stock got %h want %h", stock, mvec());
        end
    endtask

    task automatic test_drain1();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            model_pay(1);
            payout(7'd1, 0, 1'b0);
        end
        model_pay(3);
        payout(7'd3, 0, 1'b0);
        n_checks += 5;
        if (got_coins.size() != 0) begin
            n_fail++; $display("FAIL drain1_coins got %0d want 0", got_coins.size());
        end
        if (!got_err || got_done) begin
            n_fail++; $display("FAIL drain1_error got err=%b done=%b want 1 0", got_err, got_done);
        end
        if (post_err !== 1'b0) begin n_fail++; $display("FAIL drain1_errpulse got 1 want 0"); end
        if (remaining !== 7'd3) begin n_fail++; $display("FAIL drain1_rem got %0d want 3", remaining); end
        do_restock();
        if (stock[3:0] !== 4'd8) begin n_fail++; $display("FAIL drain1_restock got %0d want 8", stock[3:0]); end
    endtask

    task automatic test_reset_mid();
        int w;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        amount = 7'd50;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!coin_req && w < 10) begin
            w++;
            @(negedge clk);
        end
        n_checks += 5;
        if (!coin_req) begin n_fail++; $display("FAIL rstmid_req got 0 want 1"); end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_fill();
        if (coin_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_drop got 1 want 0"); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got 1 want 0"); end
        if (remaining !== 7'd0) begin n_fail++; $display("FAIL rstmid_rem got %0d want 0", remaining); end
        if (stock !== 16'h8888) begin n_fail++; $display("FAIL rstmid_stock got %h want 8888", stock); end
    endtask

    task automatic test_ack_wait();
        int w, cnt;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        amount = 7'd5;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!coin_req && w < 10) begin
            w++;
            @(negedge clk);
        end
        n_checks += 2;
        if (coin_sel !== 4'b0010) begin n_fail++; $display("FAIL wait_sel got %b want 0010", coin_sel); end
`ifdef CHANGE_TIMEOUT_EN
        cnt = 0;
        while (coin_req && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        n_checks += 3;
        if (cnt != 4) begin n_fail++; $display("FAIL tmo_cycles got %0d want 4", cnt); end
        if (error !== 1'b1) begin n_fail++; $display("FAIL tmo_error got %b want 1", error); end
        if (remaining !== 7'd5) begin n_fail++; $display("FAIL tmo_rem got %0d want 5", remaining); end
        @(negedge clk);
        if (stock !== mvec()) begin n_fail++; $display("FAIL tmo_stock got %h want %h", stock, mvec()); end
`else
        cnt = 0;
        while (coin_req && coin_sel == 4'b0010 && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        if (cnt != 20) begin n_fail++; $display("FAIL hold_cycles got %0d want 20", cnt); end
        coin_ack = 1'b1;
        @(negedge clk);
        coin_ack = 1'b0;
        model_pay(5);
        w = 0;
        while (!done && w < 10) begin
            w++;
            @(negedge clk);
        end
        n_checks += 2;
        if (!done) begin n_fail++; $display("FAIL hold_done got 0 want 1"); end
        if (stock !== mvec()) begin n_fail++; $display("FAIL hold_stock got %h want %h", stock, mvec()); end
`endif
    endtask

    task automatic test_random();
        int amt;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) do_restock();
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                coin_ack = 1'b1;
                @(negedge clk);
                coin_ack = 1'b0;
            end
            amt = $urandom_range(0, 127);
            model_pay(amt);
            payout(7'(amt), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            n_checks += 7;
            if (timed_out) begin n_fail++; $display("FAIL rnd%0d_timeout got none want done/error", it); end
            if (got_coins.size() != exp_coins.size()) begin
                n_fail++;
                $display("FAIL rnd%0d_count got %0d want %0d", it, got_coins.size(), exp_coins.size());
            end else begin
                for (int i = 0; i < got_coins.size(); i++) begin
                    n_checks++;
                    if (got_coins[i] !== 4'(1 << exp_coins[i])) begin
                        n_fail++;
                        $display("FAIL rnd%0d_coin%0d got %b want %b", it, i, got_coins[i],
                                 4'(1 << exp_coins[i]));
                    end
                end
            end
            if (got_done != mdone || got_err == mdone) begin
                n_fail++;
                $display("FAIL rnd%0d_outcome got done=%b err=%b want done=%b", it, got_done,
                         got_err, mdone);
            end
            if (remaining !== 7'(mrem)) begin
                n_fail++; $display("FAIL rnd%0d_rem got %0d want %0d", it, remaining, mrem);
            end
            if (stock !== mvec()) begin
                n_fail++; $display("FAIL rnd%0d_stock got %h want %h", it, stock, mvec());
            end
            if (unstable != 0) begin
                n_fail++; $display("FAIL rnd%0d_hold got %0d glitches want 0", it, unstable);
            end
            if (post_done !== 1'b0 || post_err !== 1'b0 || post_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd%0d_pulse got done=%b err=%b busy=%b want 0 0 0", it,
                         post_done, post_err, post_busy);
            end
        end
    endtask

    initial begin
        model_fill();
        test_reset();
        test_pay37();
        test_zero();
        test_drain20();
        test_drain1();
        test_reset_mid();
        test_ack_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
